// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types and score-entry helpers for the melody player
// Purpose: sequencer state encoding, ROM entry layout and special entry values.
// Ports: none (package).
package melody_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_END
    } state_t;

    localparam int DUR_W   = 3;
    localparam int NOTE_W  = 5;
    localparam int ENTRY_W = DUR_W + NOTE_W;
    localparam int DUR_LSB = NOTE_W;

    // A zero duration terminates the score; note zero is silence.
    localparam logic [DUR_W-1:0]  END_MARK = '0;
    localparam logic [NOTE_W-1:0] REST     = '0;

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
        return entry[DUR_LSB +: DUR_W];
    endfunction

    function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] entry);
        return entry[NOTE_W-1:0];
    endfunction

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [DUR_W-1:0]  dur,
                                                   input logic [NOTE_W-1:0] note);
        return {dur, note};
    endfunction

endpackage

// File: rtl/melody_player_if.sv
// rtl/melody_player_if.sv - control and note-output bundle of the melody player
// Purpose: groups playback controls and the note/gate outputs.
// Ports: start, stop (pulses), pause, loop (levels) towards the player;
//        music, note_on, busy, done, note_idx back from the player.
interface melody_player_if #(
    parameter int ADDR_W = 5
) ();

    logic                        start;
    logic                        stop;
    logic                        pause;
    logic                        loop;
    logic [melody_pkg::NOTE_W-1:0] music;
    logic                        note_on;
    logic                        busy;
    logic                        done;
    logic [ADDR_W-1:0]           note_idx;

    modport master (
        output start, stop, pause, loop,
        input  music, note_on, busy, done, note_idx
    );

    modport slave (
        input  start, stop, pause, loop,
        output music, note_on, busy, done, note_idx
    );

endinterface

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - synchronous score ROM, one-cycle read latency
// Purpose: holds SONG_LEN 8-bit entries {dur[7:5], note[4:0]}; either the built-in
//          tune below or a packed table supplied through ROM_TABLE (entry i at [8i+:8]).
// Ports: clk, addr (entry address), data (entry, registered).
module melody_rom
    import melody_pkg::*;
#(
    parameter int                     SONG_LEN  = 32,
    parameter int                     ADDR_W    = 5,
    parameter bit                     USE_TABLE = 1'b0,
    parameter logic [SONG_LEN*8-1:0]  ROM_TABLE = '0
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    logic [ENTRY_W-1:0] w_tab [2**ADDR_W];
    logic [ENTRY_W-1:0] w_default;
    logic [ENTRY_W-1:0] r_data;

    // Addresses past the song read back as the end marker.
    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_tab
        if (i < SONG_LEN) begin : g_used
            assign w_tab[i] = ROM_TABLE[i*ENTRY_W +: ENTRY_W];
        end else begin : g_pad
            assign w_tab[i] = '0;
        end
    end

    always_comb begin
        w_default = '0;
        case (int'(addr))
            0:  w_default = mk_entry(3'd1, 5'd1);
            1:  w_default = mk_entry(3'd1, 5'd1);
            2:  w_default = mk_entry(3'd1, 5'd5);
            3:  w_default = mk_entry(3'd1, 5'd5);
            4:  w_default = mk_entry(3'd1, 5'd6);
            5:  w_default = mk_entry(3'd1, 5'd6);
            6:  w_default = mk_entry(3'd2, 5'd5);
            7:  w_default = mk_entry(3'd1, 5'd4);
            8:  w_default = mk_entry(3'd1, 5'd4);
            9:  w_default = mk_entry(3'd1, 5'd3);
            10: w_default = mk_entry(3'd1, 5'd3);
            11: w_default = mk_entry(3'd1, 5'd2);
            12: w_default = mk_entry(3'd1, 5'd2);
            13: w_default = mk_entry(3'd2, 5'd1);
            14: w_default = mk_entry(3'd1, 5'd5);
            15: w_default = mk_entry(3'd1, 5'd5);
            16: w_default = mk_entry(3'd1, 5'd4);
            17: w_default = mk_entry(3'd1, 5'd4);
            18: w_default = mk_entry(3'd1, 5'd3);
            19: w_default = mk_entry(3'd1, 5'd3);
            20: w_default = mk_entry(3'd2, 5'd2);
            21: w_default = mk_entry(3'd1, 5'd5);
            22: w_default = mk_entry(3'd1, 5'd5);
            23: w_default = mk_entry(3'd1, 5'd4);
            24: w_default = mk_entry(3'd1, 5'd4);
            25: w_default = mk_entry(3'd1, 5'd3);
            26: w_default = mk_entry(3'd1, 5'd3);
            27: w_default = mk_entry(3'd2, 5'd2);
            28: w_default = mk_entry(3'd1, REST);
            29: w_default = mk_entry(3'd1, 5'd1);
            30: w_default = mk_entry(3'd2, 5'd1);
            31: w_default = mk_entry(END_MARK, REST);
            default: ;
        endcase
        if (int'(addr) >= SONG_LEN) begin
            w_default = '0;
        end
    end

    always_ff @(posedge clk) begin
        r_data <= USE_TABLE ? w_tab[addr] : w_default;
    end

    assign data = r_data;

endmodule

// File: rtl/melody_player.sv
// rtl/melody_player.sv - score sequencer producing the buzzer note index and gate
// Purpose: walks the score ROM entry by entry, holds each note for dur beats,
//          silences the tail of the last beat, and handles start/stop/pause/loop.
// Ports: clk, rst (asynchronous, active high),
//        bus (melody_player_if.slave): start/stop pulses, pause/loop levels in;
//        music, note_on, busy, done, note_idx out (all registered).
module melody_player
    import melody_pkg::*;
#(
    parameter int                    TICKS_PER_BEAT = 12_500_000,
    parameter int                    GAP_TICKS      = 1_250_000,
    parameter int                    SONG_LEN       = 32,
    parameter int                    ADDR_W         = 5,
    parameter bit                    USE_TABLE      = 1'b0,
    parameter logic [SONG_LEN*8-1:0] ROM_TABLE      = '0
) (
    input  logic           clk,
    input  logic           rst,
    melody_player_if.slave bus
);

    localparam int TICK_W = $clog2(TICKS_PER_BEAT);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [TICK_W-1:0]   r_tick;
    logic [DUR_W-1:0]    r_beat;
    logic [DUR_W-1:0]    r_dur;
    logic [NOTE_W-1:0]   r_music;
    logic                r_note_on;
    logic                r_busy;
    logic                r_done;

    logic [ENTRY_W-1:0]  w_entry;
    logic [DUR_W-1:0]    w_entry_dur;
    logic [NOTE_W-1:0]   w_entry_note;
    logic                w_tick_last;
    logic                w_beat_last;
    logic                w_in_gap;
    logic                w_note_on_cond;
    logic [ADDR_W:0]     w_addr_inc;
    logic                w_song_over;

    melody_rom #(
        .SONG_LEN  (SONG_LEN),
        .ADDR_W    (ADDR_W),
        .USE_TABLE (USE_TABLE),
        .ROM_TABLE (ROM_TABLE)
    ) u_rom (
        .clk  (clk),
        .addr (r_addr),
        .data (w_entry)
    );

    assign w_entry_dur  = entry_dur(w_entry);
    assign w_entry_note = entry_note(w_entry);

    assign w_tick_last = (r_tick == TICK_W'(TICKS_PER_BEAT - 1));
    assign w_beat_last = (r_beat == r_dur - DUR_W'(1));
    // Articulation gap: the final GAP_TICKS ticks of the note's last beat.
    assign w_in_gap    = w_beat_last && (int'(r_tick) >= TICKS_PER_BEAT - GAP_TICKS);

    assign w_note_on_cond = (r_state == ST_PLAY) && (r_music != REST) &&
                            !bus.pause && !w_in_gap;

    // One extra bit so a full 2**ADDR_W score still detects its end.
    assign w_addr_inc  = {1'b0, r_addr} + (ADDR_W + 1)'(1);
    assign w_song_over = (w_addr_inc == (ADDR_W + 1)'(SONG_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_tick    <= '0;
            r_beat    <= '0;
            r_dur     <= '0;
            r_music   <= REST;
            r_note_on <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_note_on <= w_note_on_cond;
            if (bus.stop) begin
                // Abort wins over start and over a natural end in the same cycle.
                r_state   <= ST_IDLE;
                r_addr    <= '0;
                r_tick    <= '0;
                r_beat    <= '0;
                r_music   <= REST;
                r_note_on <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_addr  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (w_entry_dur == END_MARK) begin
                            r_state <= ST_END;
                        end else if (!bus.pause) begin
                            r_music <= w_entry_note;
                            r_dur   <= w_entry_dur;
                            r_beat  <= '0;
                            r_tick  <= '0;
                            r_state <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (!bus.pause) begin
                            if (w_tick_last) begin
                                r_tick <= '0;
                                if (w_beat_last) begin
                                    // note_idx keeps the last entry when the score runs out.
                                    if (w_song_over) begin
                                        r_state <= ST_END;
                                    end else begin
                                        r_addr  <= w_addr_inc[ADDR_W-1:0];
                                        r_state <= ST_FETCH;
                                    end
                                end else begin
                                    r_beat <= r_beat + DUR_W'(1);
                                end
                            end else begin
                                r_tick <= r_tick + TICK_W'(1);
                            end
                        end
                    end
                    ST_END: begin
                        if (bus.loop) begin
                            r_addr  <= '0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_addr  <= '0;
                            r_music <= REST;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.music    = r_music;
    assign bus.note_on  = r_note_on;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.note_idx = r_addr;

endmodule

// File: doc/melody_player.md
# melody_player

Score sequencer for the buzzer path. Walks a note/duration score held in an internal ROM and drives the 5-bit note index consumed by the divisor calculator, which produces the buzzer divider value. It gates the tone with an articulation gap and supports start/pause/stop/loop control from the key-debounce logic.

## Interface
- `TICKS_PER_BEAT`, default 12_500_000: clk cycles per beat (0.25 s at 50 MHz); must be ≥ 2.
- `GAP_TICKS`, default 1_250_000: silent cycles at the end of each note's final beat; 0 ≤ GAP_TICKS < TICKS_PER_BEAT.
- `SONG_LEN`, default 32: number of ROM entries; must be 2**ADDR_W or less.
- `ADDR_W`, default 5: ROM address width.
- `clk`, input, 1: system clock, 50 MHz.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle pulse; begins playback from entry 0 when idle.
- `stop`, input, 1: one-cycle pulse; aborts playback.
- `pause`, input, 1: level; freezes playback while high.
- `loop`, input, 1: level; sampled at end of song, restarts from entry 0 when high.
- `music`, output, 5: note index to divisor calculator (0 = rest, 1–21 = notes).
- `note_on`, output, 1: buzzer gate.
- `busy`, output, 1: high in any state except IDLE.
- `done`, output, 1: one-cycle pulse at natural end of song when loop is low.
- `note_idx`, output, ADDR_W: address of the entry currently playing.

## Operation
- ROM entry is 8 bits: [7:5] is dur, a duration in beats from 1 to 7; [4:0] is the note. dur = 0 is the end-of-song marker.
- The ROM read is synchronous, with 1-cycle latency.
- States:
  - IDLE: outputs cleared.
  - On `start`, set addr = 0 and go to FETCH.
  - FETCH: ROM read issued; go to LOAD.
  - LOAD: entry valid.
    - If dur = 0, go to END.
    - Otherwise latch `music` = note, set beat_cnt = 0 and tick_cnt = 0, then go to PLAY.
  - PLAY: tick_cnt counts 0..TICKS_PER_BEAT-1. On each wrap, beat_cnt increments.
    - On the wrap of the last beat (beat_cnt = dur-1), advance addr.
    - If the new addr = SONG_LEN, go to END; otherwise go to FETCH.
  - END:
    - If `loop` is high, set addr = 0 and go to FETCH.
    - Otherwise pulse `done` and go to IDLE.
- `note_on` = (state == PLAY) && (music != 0) && !pause && !(beat_cnt == dur-1 && tick_cnt ≥ TICKS_PER_BEAT-GAP_TICKS).
- `note_on` is registered, so it aligns with `music` and lags the condition by 1 cycle.
- pause:
  - In PLAY, tick_cnt and beat_cnt hold and `music` holds.
  - Pause is also honoured in FETCH/LOAD by stalling the transition into PLAY.
  - Pause has no effect in IDLE.
- stop:
  - Forces IDLE on the next edge from any state and clears all outputs; no `done` pulse.
  - stop takes priority over start in the same cycle.
  - stop takes priority over a natural end of song in the same cycle.
- start while busy is ignored.
- `music` changes only in LOAD (or on clear). Between notes, `music` keeps the old note during FETCH/LOAD, with `note_on` low.
- No saturation or arithmetic overflow is possible. tick_cnt is wide enough for TICKS_PER_BEAT-1 (clog2 width) and beat_cnt is 3 bits.

## Timing
- Reset values: `music` = 0, `note_on` = 0, `busy` = 0, `done` = 0, `note_idx` = 0, state IDLE.
- Counting from the `start` pulse at edge 0:
  - FETCH at edge 1.
  - LOAD at edge 2.
  - PLAY at edge 3, with `music` valid.
  - `note_on` first high after edge 4.
- Each note occupies dur·TICKS_PER_BEAT PLAY cycles plus 2 cycles (FETCH+LOAD) of forced silence before the next note.
- Paused cycles add to the duration exactly.
- `done` is asserted for exactly 1 cycle, the cycle after END. `busy` falls in the same cycle that `done` rises.
- `rst` mid-note takes effect immediately (asynchronous) and restores all reset values.

## Structure
- Package `melody_pkg` holds:
  - the state enum (IDLE, FETCH, LOAD, PLAY, END);
  - entry field widths and positions (DUR_W = 3, NOTE_W = 5);
  - the END_MARK = 0 constant;
  - the REST = 0 constant.
- Sub-module `melody_rom`: synchronous ROM with SONG_LEN × 8-bit entries, initialised from a case table; exposes `addr` in and `data` out. The bench overrides it via a parameterised test table.

## Test plan
Bench parameters: TICKS_PER_BEAT = 8, GAP_TICKS = 2. Test score: {note 1 dur 1, note 0 dur 2, note 8 dur 1, end}.

- **Basic playback.** Stimulus: start pulse, loop = 0.
  - `music` = 1 for 8 PLAY cycles; `note_on` is high for 6 of them.
  - Then `music` = 0 with `note_on` low for 16 cycles.
  - Then `music` = 8.
  - `done` pulses once; `busy` is low afterwards.
- **Pause.** Stimulus: pause held 5 cycles mid note 1.
  - `note_on` low for those 5 cycles; `music` stays 1.
  - Note 1 total duration extends from 8 to 13 cycles.
- **Stop.** Stimulus: stop during note 8, with stop and start asserted together.
  - Next cycle: IDLE, `music` = 0, `busy` = 0, no `done` pulse.
  - The start asserted together with stop is ignored.
- **Loop.** Stimulus: loop = 1 at end of song.
  - `note_idx` returns to 0 and `music` = 1 again, 2 cycles after END.
  - No `done` pulse.
- **Reset.** Stimulus: assert `rst` mid-gap of note 1, asynchronously.
  - All outputs go to reset values within the same cycle.
  - A start after release replays from entry 0.
- **Full ROM.** Stimulus: SONG_LEN entries with no end marker.
  - Playback ends after entry SONG_LEN-1 and `done` pulses.
  - Start while busy has no effect on `note_idx`.
